boid_frame_writer: RTL
======================

# boid_frame_writer

Sequencer between the boid processor units and the resettable boid display RAM. On each VGA end-of-frame pulse it issues one clear pulse to the display RAM, then walks every boid slot in turn, latches that boid's x/y, and writes its pixel footprint into the RAM as linear pixel addresses. It replaces the ad-hoc end-of-frame counter logic in the top level with a defined FSM that has deterministic latency, edge clipping and overrun accounting.

## Interface

Parameters:
- MAX_BOIDS, 4, number of boid slots to scan
- BITS_FOR_BOIDS, $clog2(MAX_BOIDS), width of the slot select
- VIDEO_WIDTH, 640, visible pixels per line
- VIDEO_HEIGHT, 480, visible lines
- ADDR_WIDTH, 19, display RAM address width
- SPRITE_SIZE, 2, sprite edge length in pixels (used only with BOID_SPRITE_EN)

Ports:
- clock  in  1  single system clock; all logic on the rising edge
- reset  in  1  synchronous, active-high
- screen_end  in  1  one-cycle end-of-frame pulse from the VGA controller
- boid_sel  out  BITS_FOR_BOIDS  slot index that drives the BPU output mux
- boid_x  in  10  x of the selected boid, combinational from boid_sel
- boid_y  in  9  y of the selected boid, combinational from boid_sel
- ram_clear  out  1  one-cycle pulse that switches the RAM to a clear buffer
- ram_we  out  1  display RAM write enable; write data is always 1
- ram_addr  out  ADDR_WIDTH  display RAM write address
- busy  out  1  high from the cycle after accepting screen_end until frame_done
- frame_done  out  1  one-cycle pulse on the final draw cycle
- overrun_count  out  8  saturating count of screen_end pulses dropped while busy

## Operation

- States: IDLE, CLEAR, FETCH, DRAW, DONE.
- IDLE:
  - screen_end=1 moves to CLEAR and sets busy.
  - All outputs are 0 except overrun_count.
- CLEAR:
  - Asserts ram_clear for exactly one cycle.
  - Sets boid_sel=0, then moves to FETCH.
- FETCH:
  - Latches boid_x/boid_y into x0/y0 and zeroes the sprite offsets dx/dy.
  - ram_we=0. Moves to DRAW.
- DRAW:
  - One pixel per cycle at (x0+dx, y0+dy).
  - dx increments first; when it wraps at SPRITE_SIZE-1, dy increments.
  - On the last offset: if boid_sel==MAX_BOIDS-1, move to DONE; otherwise increment boid_sel and move to FETCH.
- DONE:
  - Drops busy and returns to IDLE. frame_done is asserted in the last DRAW cycle, not in DONE.
- Address arithmetic:
  - ram_addr = py*VIDEO_WIDTH + px, computed as (py<<9)+(py<<7)+px for the default width.
  - Intermediates are 20 bits wide; the result is truncated to ADDR_WIDTH.
- Clipping:
  - If px>=VIDEO_WIDTH or py>=VIDEO_HEIGHT, ram_we=0 for that cycle, but the cycle is still consumed, so latency stays fixed.
  - This applies to latched coordinates that are already out of range as well as to sprite pixels that spill past an edge.
- Overrun:
  - A screen_end seen while busy (CLEAR through DONE) is ignored and increments overrun_count, saturating at 255.
  - overrun_count is cleared only by reset.
- Reset:
  - Valid mid-frame. Next cycle: state=IDLE, and boid_sel, ram_clear, ram_we, ram_addr, busy, frame_done and overrun_count are all 0.
  - The partial frame is abandoned; no clear pulse is issued.

## Timing

- screen_end sampled high at edge N gives ram_clear high during cycle N+1.
- The first FETCH is at N+2, the first draw at N+3.
- Pixels per boid: P = SPRITE_SIZE² with the macro, 1 without.
- Each boid takes 1+P cycles; the frame takes 1 + MAX_BOIDS*(1+P) cycles from CLEAR to the last DRAW, inclusive.
- ram_we and ram_addr are registered and valid in the same cycle, as required by the RAM's synchronous write.
- boid_sel changes on the edge that enters FETCH. boid_x/boid_y must settle within that cycle.
- A screen_end coincident with DONE counts as an overrun. One coincident with IDLE is accepted.

## Configuration

- BOID_SPRITE_EN defined: each boid draws a SPRITE_SIZE×SPRITE_SIZE square anchored at its top-left (x0,y0).
- BOID_SPRITE_EN undefined: P=1, a single pixel at (x0,y0). The dx/dy counters are removed and DRAW lasts one cycle per boid.

## Structure

- Package boid_pkg holds:
  - VIDEO_WIDTH, VIDEO_HEIGHT, PIXEL_COUNT, ADDR_WIDTH
  - the FSM state encoding (3-bit: IDLE=0, CLEAR=1, FETCH=2, DRAW=3, DONE=4)
  - overrun counter width
- One sub-module, pixel_addr_calc: purely combinational (px, py) -> (addr, in_bounds), reused by the VGA read path.

## Test plan

- Reset, then idle 10 cycles -> every output 0, no ram_we.
- MAX_BOIDS=4, SPRITE_SIZE=2, macro on; boid0=(10,20), others (100,100) (200,50) (300,400); pulse screen_end at cycle 0:
  - ram_clear at cycle 1.
  - Boid0 writes 12810, 12811, 13450, 13451 on cycles 3-6.
  - frame_done on cycle 21; busy low at cycle 22.
- Boid at (639,479) with macro on -> a single write at 307199; the three remaining cycles have ram_we=0; total latency unchanged.
- Macro off, same four boids -> exactly 4 writes, including 12810 for boid0; frame_done at cycle 9.
- Pulse screen_end three extra times while busy -> overrun_count=3 and no extra ram_clear. A pulse in the cycle after busy falls starts a new frame.
- Assert reset during boid 2's DRAW -> all outputs 0 next cycle. A following screen_end runs a complete, correct frame.

Source files
------------

// File: rtl/boid_pkg.sv
// Shared constants, FSM encoding and helpers for the boid display path.
// Latency: none; package contents only.
// Backpressure: not applicable.
package boid_pkg;

    localparam int VIDEO_WIDTH  = 640;
    localparam int VIDEO_HEIGHT = 480;
    localparam int PIXEL_COUNT  = VIDEO_WIDTH * VIDEO_HEIGHT;
    localparam int ADDR_WIDTH   = 19;

    // Width and ceiling of the dropped-frame counter
    localparam int                OVR_W   = 8;
    localparam logic [OVR_W-1:0]  OVR_MAX = '1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_FETCH = 3'd2,
        ST_DRAW  = 3'd3,
        ST_DONE  = 3'd4
    } fsm_state_t;

    // Increment that sticks at the ceiling instead of wrapping
    function automatic logic [OVR_W-1:0] sat_inc(input logic [OVR_W-1:0] v);
        return (v == OVR_MAX) ? v : v + {{(OVR_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/boid_frame_writer_pixel_addr_calc.sv
// Maps a pixel coordinate to a linear display RAM address plus an on-screen flag.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows input every cycle.
module pixel_addr_calc #(
    parameter int VIDEO_WIDTH  = boid_pkg::VIDEO_WIDTH,
    parameter int VIDEO_HEIGHT = boid_pkg::VIDEO_HEIGHT,
    parameter int ADDR_WIDTH   = boid_pkg::ADDR_WIDTH
) (
    input  logic [10:0]           px,
    input  logic [9:0]            py,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  in_bounds
);

    localparam logic [10:0] W_LIM = 11'(VIDEO_WIDTH);
    localparam logic [9:0]  H_LIM = 10'(VIDEO_HEIGHT);

    logic [19:0] py_w;
    logic [19:0] px_w;
    logic [19:0] lin;

    assign py_w = {10'b0, py};
    assign px_w = {9'b0, px};

    // 640 = 512 + 128, so the standard width needs only two shifts and an add
    generate
        if (VIDEO_WIDTH == 640) begin : g_shift
            assign lin = (py_w << 9) + (py_w << 7) + px_w;
        end else begin : g_mult
            assign lin = py_w * 20'(VIDEO_WIDTH) + px_w;
        end
    endgenerate

    assign addr      = ADDR_WIDTH'(lin);
    assign in_bounds = (px < W_LIM) && (py < H_LIM);

endmodule

// File: rtl/boid_frame_writer.sv
// Per-frame sequencer: clears the boid display RAM, then writes each boid's footprint.
// Latency: clear 1 cycle after screen_end, frame = 1 + MAX_BOIDS*(1+P) cycles; BOID_SPRITE_EN selects PxP sprites.
// Backpressure: none; screen_end while busy is dropped and counted in overrun_count.
module boid_frame_writer #(
    parameter int MAX_BOIDS      = 4,
    parameter int BITS_FOR_BOIDS = $clog2(MAX_BOIDS),
    parameter int VIDEO_WIDTH    = boid_pkg::VIDEO_WIDTH,
    parameter int VIDEO_HEIGHT   = boid_pkg::VIDEO_HEIGHT,
    parameter int ADDR_WIDTH     = boid_pkg::ADDR_WIDTH,
    parameter int SPRITE_SIZE    = 2
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      screen_end,
    output logic [BITS_FOR_BOIDS-1:0] boid_sel,
    input  logic [9:0]                boid_x,
    input  logic [8:0]                boid_y,
    output logic                      ram_clear,
    output logic                      ram_we,
    output logic [ADDR_WIDTH-1:0]     ram_addr,
    output logic                      busy,
    output logic                      frame_done,
    output logic [7:0]                overrun_count
);

    import boid_pkg::*;

    fsm_state_t state;

    logic                  cur_last;   // current DRAW pixel is the boid's last
    logic                  next_last;  // pixel being loaded this edge is the boid's last
    logic                  sel_last;
    logic [10:0]           calc_px;
    logic [9:0]            calc_py;
    logic [ADDR_WIDTH-1:0] pix_addr;
    logic                  pix_ok;

    assign sel_last = (boid_sel == BITS_FOR_BOIDS'(MAX_BOIDS - 1));

`ifdef BOID_SPRITE_EN
    localparam int OFS_W = (SPRITE_SIZE > 1) ? $clog2(SPRITE_SIZE) : 1;
    localparam logic [OFS_W-1:0] OFS_LAST = OFS_W'(SPRITE_SIZE - 1);

    logic [9:0]       x0;
    logic [8:0]       y0;
    logic [OFS_W-1:0] dx, dy;
    logic [OFS_W-1:0] nx, ny;

    // Next sprite offset: dx runs fastest, dy steps when dx wraps; FETCH loads (0,0)
    always_comb begin
        nx = '0;
        ny = '0;
        if (state == ST_DRAW) begin
            if (dx == OFS_LAST) begin
                nx = '0;
                ny = dy + OFS_W'(1);
            end else begin
                nx = dx + OFS_W'(1);
                ny = dy;
            end
        end
    end

    assign cur_last  = (dx == OFS_LAST) && (dy == OFS_LAST);
    assign next_last = (nx == OFS_LAST) && (ny == OFS_LAST);
    // In FETCH the anchor is still on the bus; afterwards it comes from x0/y0
    assign calc_px = ((state == ST_FETCH) ? {1'b0, boid_x} : {1'b0, x0}) + 11'(nx);
    assign calc_py = ((state == ST_FETCH) ? {1'b0, boid_y} : {1'b0, y0}) + 10'(ny);
`else
    assign cur_last  = 1'b1;
    assign next_last = 1'b1;
    assign calc_px   = {1'b0, boid_x};
    assign calc_py   = {1'b0, boid_y};
`endif

    pixel_addr_calc #(
        .VIDEO_WIDTH  (VIDEO_WIDTH),
        .VIDEO_HEIGHT (VIDEO_HEIGHT),
        .ADDR_WIDTH   (ADDR_WIDTH)
    ) u_addr (
        .px        (calc_px),
        .py        (calc_py),
        .addr      (pix_addr),
        .in_bounds (pix_ok)
    );

    // Frame sequencer; every output is registered so it lines up with its state
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= ST_IDLE;
            boid_sel      <= '0;
            ram_clear     <= 1'b0;
            ram_we        <= 1'b0;
            ram_addr      <= '0;
            busy          <= 1'b0;
            frame_done    <= 1'b0;
            overrun_count <= '0;
`ifdef BOID_SPRITE_EN
            x0            <= '0;
            y0            <= '0;
            dx            <= '0;
            dy            <= '0;
`endif
        end else begin
            ram_clear  <= 1'b0;
            ram_we     <= 1'b0;
            ram_addr   <= '0;
            frame_done <= 1'b0;

            if (screen_end && (state != ST_IDLE))
                overrun_count <= sat_inc(overrun_count);

            case (state)
                ST_IDLE: begin
                    if (screen_end) begin
                        state     <= ST_CLEAR;
                        ram_clear <= 1'b1;
                        busy      <= 1'b1;
                        boid_sel  <= '0;
                    end
                end
                ST_CLEAR: begin
                    boid_sel <= '0;
                    state    <= ST_FETCH;
                end
                ST_FETCH: begin
`ifdef BOID_SPRITE_EN
                    x0 <= boid_x;
                    y0 <= boid_y;
                    dx <= '0;
                    dy <= '0;
`endif
                    state      <= ST_DRAW;
                    ram_we     <= pix_ok;
                    ram_addr   <= pix_addr;
                    frame_done <= next_last && sel_last;
                end
                ST_DRAW: begin
                    if (cur_last) begin
                        if (sel_last) begin
                            state    <= ST_DONE;
                            busy     <= 1'b0;
                            boid_sel <= '0;
                        end else begin
                            boid_sel <= boid_sel + BITS_FOR_BOIDS'(1);
                            state    <= ST_FETCH;
                        end
                    end
`ifdef BOID_SPRITE_EN
                    else begin
                        dx         <= nx;
                        dy         <= ny;
                        ram_we     <= pix_ok;
                        ram_addr   <= pix_addr;
                        frame_done <= next_last && sel_last;
                    end
`endif
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
